// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM requester, memory and stall signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall;

    // master: the arbiter itself; slave: core requesters plus the memory
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter in front of a single-port fixed-latency memory
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]      LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);

    logic [1:0]            state;
    logic [1:0]            owner;
    logic [3:0]            lat_cnt;
    logic [SW-1:0]         starve_cnt;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic                  grant_dm;
    logic                  grant_if;

    // DM wins unless IF has already watched STARVE_MAX DM grants go by
    always_comb begin
        grant_dm = bus.dm_req && !(bus.if_req && (starve_cnt == STARVE_TOP));
        grant_if = bus.if_req && !grant_dm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner    <= OWN_DM;
                        mem_we_q <= bus.dm_we;
                        addr_q   <= bus.dm_addr;
                        wdata_q  <= bus.dm_wdata;
                        state    <= ISSUE;
                    end else if (grant_if) begin
                        owner    <= OWN_IF;
                        mem_we_q <= 1'b0;
                        addr_q   <= bus.if_addr;
                        state    <= ISSUE;
                    end
                    if (!bus.if_req || grant_if) begin
                        starve_cnt <= '0;
                    end else if (grant_dm && (starve_cnt != STARVE_TOP)) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        // write completions leave dm_rdata untouched
                        if (owner == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                        end else if (!mem_we_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_done   = (state == DONE) && (owner == OWN_IF);
    assign bus.dm_done   = (state == DONE) && (owner == OWN_DM);
    assign bus.stall     = (bus.if_req && !bus.if_done) || (bus.dm_req && !bus.dm_done);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int SLOT = LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus5 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX))
        dut  (.clk(clk), .rst(rst), .bus(bus));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(1), .STARVE_MAX(SMAX))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(5), .STARVE_MAX(SMAX))
        dut5 (.clk(clk), .rst(rst), .bus(bus5));

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;
    typedef struct { int cyc; logic [DW-1:0] data; } done_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] store [logic [AW-1:0]];
    acc_t          mem_log[$];
    done_t         if_log[$];
    done_t         dm_log[$];
    int            due_q[$];
    logic [DW-1:0] rsp_q[$];
    int            en_run_bad = 0, if_chg_bad = 0, dm_chg_bad = 0;
    logic          prev_en = 1'b0;
    logic [DW-1:0] prev_if = '0, prev_dm = '0;
    int            done1_cyc = -1, done5_cyc = -1;
    logic [DW-1:0] data1 = '0, data5 = '0;
    int            nvec = 0, nerr = 0;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return store.exists(a) ? store[a] : (a ^ 32'h5A5A_C3C3);
    endfunction

    // memory model and event recorder, all observed mid-cycle
    always @(negedge clk) begin
        acc_t  e;
        done_t d;
        if (rst) begin
            prev_en = 1'b0;
            prev_if = bus.if_rdata;
            prev_dm = bus.dm_rdata;
        end else begin
            if (bus.mem_en) begin
                if (prev_en) en_run_bad++;
                e.cyc = cyc; e.we = bus.mem_we; e.addr = bus.mem_addr; e.wdata = bus.mem_wdata;
                mem_log.push_back(e);
                rsp_q.push_back(mem_val(bus.mem_addr));
                due_q.push_back(cyc + LAT);
                if (bus.mem_we) store[bus.mem_addr] = bus.mem_wdata;
            end
            if (bus.if_done) begin d.cyc = cyc; d.data = bus.if_rdata; if_log.push_back(d); end
            if (bus.dm_done) begin d.cyc = cyc; d.data = bus.dm_rdata; dm_log.push_back(d); end
            if (bus.if_rdata !== prev_if && !bus.if_done) if_chg_bad++;
            if (bus.dm_rdata !== prev_dm && !bus.dm_done) dm_chg_bad++;
            prev_en = bus.mem_en;
            prev_if = bus.if_rdata;
            prev_dm = bus.dm_rdata;
            if (bus1.if_done && done1_cyc < 0) begin done1_cyc = cyc; data1 = bus1.if_rdata; end
            if (bus5.if_done && done5_cyc < 0) begin done5_cyc = cyc; data5 = bus5.if_rdata; end
        end
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(rsp_q.pop_front());
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            bus.mem_rdata = rsp_q.pop_front();
        end else begin
            bus.mem_rdata = 32'hBAD0_BAD0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // waits for the chosen done pulse, then drops that request on the edge ending it
    task automatic wait_done(input bit dm, input int limit, input string tag);
        int k = 0;
        @(negedge clk);
        while (!(dm ? bus.dm_done : bus.if_done) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, 64'(k < limit), 64'd1);
        @(posedge clk);
        #1;
        if (dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
    endtask

    task automatic clear_logs();
        mem_log.delete();
        if_log.delete();
        dm_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            t0, tr, k, n_dm;
        bit            if_seen;
        logic [AW-1:0] a_if, a_dm;
        logic [DW-1:0] d, exp_dm, lat1_d, lat5_d;
        bit            exp_stall;

        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0;
        lat1_d = $urandom; lat5_d = $urandom;
        bus1.if_req = 0; bus1.if_addr = 32'h100; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = '0; bus1.dm_wdata = '0; bus1.mem_rdata = lat1_d;
        bus5.if_req = 0; bus5.if_addr = 32'h200; bus5.dm_req = 0; bus5.dm_we = 0;
        bus5.dm_addr = '0; bus5.dm_wdata = '0; bus5.mem_rdata = lat5_d;
        exp_dm = '0;

        // reset state
        tick(3);
        check("rst_ctrl", 64'({bus.mem_en, bus.mem_we, bus.if_done, bus.dm_done, bus.stall}), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'd0);
        rst = 1'b0;
        tick(2);

        // IF-only read
        clear_logs();
        store[32'h40] = 32'h2010FFFF;
        t0 = cyc; bus.if_addr = 32'h40; bus.if_req = 1'b1;
        wait_done(0, 20, "if_only");
        check("if_only_cnt", 64'(if_log.size()), 64'd1);
        check("if_only_cyc", 64'(if_log[0].cyc), 64'(t0 + LAT + 2));
        check("if_only_data", 64'(if_log[0].data), 64'h2010FFFF);
        check("if_only_en_cnt", 64'(mem_log.size()), 64'd1);
        check("if_only_en_cyc", 64'(mem_log[0].cyc), 64'(t0 + 1));
        check("if_only_en", {31'd0, mem_log[0].we, mem_log[0].addr}, 64'h40);
        check("if_only_no_dm", 64'(dm_log.size()), 64'd0);

        // DM write, then read back
        clear_logs();
        t0 = cyc; bus.dm_we = 1'b1; bus.dm_addr = 32'h08; bus.dm_wdata = 32'hDEADBEEF; bus.dm_req = 1'b1;
        wait_done(1, 20, "dm_wr");
        check("dm_wr_cyc", 64'(dm_log[0].cyc), 64'(t0 + LAT + 2));
        check("dm_wr_rdata_hold", 64'(dm_log[0].data), 64'(exp_dm));
        check("dm_wr_en_cnt", 64'(mem_log.size()), 64'd1);
        check("dm_wr_en", {31'd0, mem_log[0].we, mem_log[0].addr}, {31'd0, 1'b1, 32'h08});
        check("dm_wr_wdata", 64'(mem_log[0].wdata), 64'hDEADBEEF);
        clear_logs();
        t0 = cyc; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
        wait_done(1, 20, "dm_rd");
        exp_dm = 32'hDEADBEEF;
        check("dm_rd_cyc", 64'(dm_log[0].cyc), 64'(t0 + LAT + 2));
        check("dm_rd_data", 64'(dm_log[0].data), 64'(exp_dm));

        // simultaneous requests: DM first, IF straight after
        clear_logs();
        a_if = $urandom; a_dm = $urandom;
        t0 = cyc; bus.if_addr = a_if; bus.dm_addr = a_dm; bus.dm_we = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            exp_stall = (c < 2 * SLOT - 1) || (c < LAT + 2);
            check($sformatf("both_stall_%0d", c), 64'(bus.stall), 64'(exp_stall));
            @(posedge clk);
            #1;
            if (c == LAT + 2) bus.dm_req = 1'b0;
            if (c == 2 * SLOT - 1) bus.if_req = 1'b0;
        end
        exp_dm = mem_val(a_dm);
        check("both_dm_cyc", 64'(dm_log[0].cyc), 64'(t0 + LAT + 2));
        check("both_dm_data", 64'(dm_log[0].data), 64'(exp_dm));
        check("both_if_cyc", 64'(if_log[0].cyc), 64'(t0 + SLOT + LAT + 2));
        check("both_if_data", 64'(if_log[0].data), 64'(mem_val(a_if)));
        check("both_order", {mem_log[0].addr, mem_log[1].addr}, {a_dm, a_if});

        // starvation guard, twice to show the count restarts after the IF grant
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            t0 = cyc; if_seen = 0; k = 0; n_dm = 0;
            a_if = $urandom;
            bus.if_addr = a_if; bus.dm_addr = $urandom; bus.dm_we = 1'($urandom_range(0, 1));
            bus.dm_wdata = $urandom;
            bus.if_req = 1'b1; bus.dm_req = 1'b1;
            while (!if_seen && k < 200) begin
                @(negedge clk);
                k++;
                if (bus.dm_done) begin
                    if (!bus.dm_we) exp_dm = mem_val(bus.dm_addr);
                    check($sformatf("starve_dm_rdata_%0d_%0d", r, n_dm), 64'(bus.dm_rdata), 64'(exp_dm));
                    n_dm++;
                    @(posedge clk);
                    #1;
                    bus.dm_addr = $urandom; bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
                end else if (bus.if_done) begin
                    @(posedge clk);
                    #1;
                    bus.if_req = 1'b0; bus.dm_req = 1'b0; if_seen = 1;
                end
            end
            check("starve_timeout", 64'(if_seen), 64'd1);
            check("starve_dm_cnt", 64'(dm_log.size()), 64'(SMAX));
            check("starve_if_cyc", 64'(if_log[0].cyc), 64'(t0 + SMAX * SLOT + LAT + 2));
            check("starve_if_data", 64'(if_log[0].data), 64'(mem_val(a_if)));
            check("starve_last", {31'd0, mem_log[SMAX].we, mem_log[SMAX].addr}, {32'd0, a_if});
        end

        // reset during WAIT of a DM read, pending IF then completes
        clear_logs();
        t0 = cyc; bus.dm_we = 1'b0; bus.dm_addr = $urandom; bus.dm_req = 1'b1;
        tick(2);
        a_if = $urandom; bus.if_addr = a_if; bus.if_req = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({bus.mem_en, bus.dm_done, bus.if_done}), 64'd0);
        check("rst_mid_rdata", {bus.if_rdata, bus.dm_rdata}, 64'd0);
        bus.dm_req = 1'b0; exp_dm = '0;
        @(posedge clk);
        #1;
        rst = 1'b0; tr = cyc;
        wait_done(0, 20, "rst_if");
        check("rst_if_cyc", 64'(if_log[0].cyc), 64'(tr + LAT + 2));
        check("rst_if_data", 64'(if_log[0].data), 64'(mem_val(a_if)));
        check("rst_no_dm_done", 64'(dm_log.size()), 64'd0);
        check("rst_dm_rdata", 64'(bus.dm_rdata), 64'(exp_dm));

        // random DM write followed by IF read of the same word
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            a_dm = $urandom; d = $urandom;
            bus.dm_we = 1'b1; bus.dm_addr = a_dm; bus.dm_wdata = d; bus.dm_req = 1'b1;
            wait_done(1, 20, "rnd_wr");
            t0 = cyc; bus.if_addr = a_dm; bus.if_req = 1'b1;
            wait_done(0, 20, "rnd_rd");
            check($sformatf("rnd_rd_data_%0d", i), 64'(if_log[0].data), 64'(d));
            check($sformatf("rnd_rd_cyc_%0d", i), 64'(if_log[0].cyc), 64'(t0 + LAT + 2));
            check($sformatf("rnd_dm_hold_%0d", i), 64'(dm_log[0].data), 64'(exp_dm));
        end

        // latency builds 1 and 5
        t0 = cyc; bus1.if_req = 1'b1; bus5.if_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            if (done1_cyc >= 0) bus1.if_req = 1'b0;
            if (done5_cyc >= 0) bus5.if_req = 1'b0;
        end
        check("lat1_cyc", 64'(done1_cyc), 64'(t0 + 3));
        check("lat1_data", 64'(data1), 64'(lat1_d));
        check("lat5_cyc", 64'(done5_cyc), 64'(t0 + 7));
        check("lat5_data", 64'(data5), 64'(lat5_d));

        check("mem_en_one_cycle", 64'(en_run_bad), 64'd0);
        check("if_rdata_stable", 64'(if_chg_bad), 64'd0);
        check("dm_rdata_stable", 64'(dm_chg_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
